// File: rtl/key_cond_pkg.sv
// Shared types and widths for the push-button conditioner.
// Debounce counter covers DEBOUNCE_CYCLES up to 255; repeat counter covers REPEAT_DELAY up to 4095.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_DN,
        HELD,
        DEB_UP
    } key_state_t;

    localparam int DEB_CNT_W = 8;
    localparam int REP_CNT_W = 12;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce FSM, optional hold-to-repeat (KEY_REPEAT_EN).
// Latency: DEBOUNCE_CYCLES+2 cycles from pin edge to held/press/release_pulse.
// Backpressure: none; pulses are single-cycle events that are never stalled.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 32,
    parameter int REPEAT_DELAY    = 1536,
    parameter int REPEAT_PERIOD   = 384
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic press,
    output logic release_pulse
);

    localparam logic [DEB_CNT_W-1:0] DEB_ONE  = DEB_CNT_W'(1);
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES);

    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
        REPEAT_DELAY > (2**REP_CNT_W) - 1) begin : g_bad_repeat
        $error("key_channel: REPEAT_PERIOD must be 1..REPEAT_DELAY and REPEAT_DELAY fit the repeat counter");
    end

    logic [1:0]           sync;
    logic                 pressed_s;
    key_state_t           state;
    logic [DEB_CNT_W-1:0] deb_cnt;
    logic                 deb_done;
    logic                 rep_fire;

    // Synchroniser idles at "released" so a key held through reset still debounces.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign pressed_s = ~sync[1];
    assign deb_done  = (deb_cnt + DEB_ONE) == DEB_LAST;

`ifdef KEY_REPEAT_EN
    localparam logic [REP_CNT_W-1:0] REP_ONE    = REP_CNT_W'(1);
    localparam logic [REP_CNT_W-1:0] REP_FIRST  = REP_CNT_W'(REPEAT_DELAY);
    localparam logic [REP_CNT_W-1:0] REP_RELOAD = REP_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_CNT_W-1:0] rep_cnt;

    assign rep_fire = (state == HELD) && pressed_s && ((rep_cnt + REP_ONE) == REP_FIRST);

    // After each repeat the counter rewinds by one period, so later pulses land every REPEAT_PERIOD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt <= '0;
        end else if (state == HELD && pressed_s) begin
            rep_cnt <= rep_fire ? REP_RELOAD : rep_cnt + REP_ONE;
        end else if (state == IDLE || state == DEB_DN) begin
            rep_cnt <= '0;
        end else if (state == DEB_UP && !pressed_s && deb_done) begin
            rep_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rep_fire;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_s) begin
                        state   <= DEB_DN;
                        deb_cnt <= DEB_ONE;
                    end
                end
                DEB_DN: begin
                    if (!pressed_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                        held    <= 1'b1;
                        press   <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end
                HELD: begin
                    if (!pressed_s) begin
                        state   <= DEB_UP;
                        deb_cnt <= DEB_ONE;
                    end
                end
                DEB_UP: begin
                    if (pressed_s) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        state         <= IDLE;
                        deb_cnt       <= '0;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS active-low push-buttons into held levels and press/release pulses; KEY_REPEAT_EN adds hold-to-repeat.
// Latency: DEBOUNCE_CYCLES+2 cycles; backpressure: none (release_pulse carries "release", a reserved word).
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 32,
    parameter int REPEAT_DELAY    = 1536,
    parameter int REPEAT_PERIOD   = 384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_n,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**DEB_CNT_W) - 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be within 2..255");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .key_n         (keys_n[i]),
            .held          (held[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: run-length reference model compared every cycle,
// plus directed scenarios with hand-computed cycle expectations.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic [N-1:0] keys_n = 4'b1111;
    logic [N-1:0] held;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_n        (keys_n),
        .held          (held),
        .press         (press),
        .release_pulse (release_pulse)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's level flips once D consecutive synchronised samples disagree with it.
    logic [N-1:0] m_held  = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    logic [N-1:0] h1      = '1;
    logic [N-1:0] h2      = '1;
    logic         m_ps;
    int           run [N];
`ifdef KEY_REPEAT_EN
    logic         m_steady;
    int           age [N];
`endif

    initial begin
        for (int k = 0; k < N; k++) run[k] = 0;
`ifdef KEY_REPEAT_EN
        for (int k = 0; k < N; k++) age[k] = 0;
`endif
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_held = '0; m_press = '0; m_rel = '0; h1 = '1; h2 = '1;
                for (int k = 0; k < N; k++) run[k] = 0;
`ifdef KEY_REPEAT_EN
                for (int k = 0; k < N; k++) age[k] = 0;
`endif
            end else begin
                for (int k = 0; k < N; k++) begin
                    m_ps = ~h2[k];
`ifdef KEY_REPEAT_EN
                    m_steady = m_held[k] && (run[k] == 0) && m_ps;
`endif
                    m_press[k] = 1'b0;
                    m_rel[k]   = 1'b0;
                    run[k] = (m_ps != m_held[k]) ? run[k] + 1 : 0;
                    if (run[k] == D) begin
                        run[k] = 0;
                        m_held[k] = ~m_held[k];
                        if (m_held[k]) begin
                            m_press[k] = 1'b1;
`ifdef KEY_REPEAT_EN
                            age[k] = 0;
`endif
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end
`ifdef KEY_REPEAT_EN
                    else if (m_steady) begin
                        age[k]++;
                        if (age[k] == RD || (age[k] > RD && (age[k] - RD) % RP == 0))
                            m_press[k] = 1'b1;
                    end
`endif
                end
                h2 = h1;
                h1 = keys_n;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("model_held",    held,          m_held);
            check("model_press",   press,         m_press);
            check("model_release", release_pulse, m_rel);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [N-1:0] v);
        @(negedge clk);
        keys_n = v;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #23;
        check("reset_held",    held,          4'b0000);
        check("reset_press",   press,         4'b0000);
        check("reset_release", release_pulse, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        edges(4);

        // Clean press and release of key 0
        drive(4'b1110);
        edges(5); check("clean_press_c5", press, 4'b0000);
        edges(1); check("clean_press_c6", press, 4'b0001);
                  check("clean_held_c6",  held,  4'b0001);
        edges(1); check("clean_press_c7", press, 4'b0000);
                  check("clean_held_c7",  held,  4'b0001);
        drive(4'b1111);
        edges(5); check("clean_rel_c5",   release_pulse, 4'b0000);
        edges(1); check("clean_rel_c6",   release_pulse, 4'b0001);
                  check("clean_rheld_c6", held,          4'b0000);
        edges(1); check("clean_rel_c7",   release_pulse, 4'b0000);
        edges(4);

        // Bouncing press on key 1
        drive(4'b1101); drive(4'b1111); drive(4'b1101); drive(4'b1111);
        drive(4'b1101);
        edges(5); check("bounce_press_c5", press, 4'b0000);
        edges(1); check("bounce_press_c6", press, 4'b0010);
        edges(1); check("bounce_press_c7", press, 4'b0000);
        drive(4'b1111);
        edges(10);

        // Release of key 2 with a one-cycle re-press inside the debounce window
        drive(4'b1011);
        edges(8); check("glitch_pre_held", held, 4'b0100);
        drive(4'b1111); drive(4'b1111); drive(4'b1011); drive(4'b1111);
        for (int c = 1; c <= 5; c++) begin
            edges(1);
            check($sformatf("glitch_held_c%0d", c), held,          4'b0100);
            check($sformatf("glitch_rel_c%0d", c),  release_pulse, 4'b0000);
        end
        edges(1); check("glitch_rel_c6",  release_pulse, 4'b0100);
                  check("glitch_held_c6", held,          4'b0000);
        edges(4);

        // All four keys together
        drive(4'b0000);
        edges(5); check("all_press_c5", press, 4'b0000);
        edges(1); check("all_press_c6", press, 4'b1111);
                  check("all_held_c6",  held,  4'b1111);
        edges(1); check("all_press_c7", press, 4'b0000);
        drive(4'b1111);
        edges(5); check("all_rel_c5",   release_pulse, 4'b0000);
        edges(1); check("all_rel_c6",   release_pulse, 4'b1111);
        edges(1); check("all_rel_c7",   release_pulse, 4'b0000);
        edges(4);

        // Reset while key 0 is held and key 3 is mid-debounce
        drive(4'b1110);
        edges(8); check("rst_pre_held", held, 4'b0001);
        drive(4'b0110);
        edges(3);
        reset = 1'b0;
        #1;
        check("rst_async_held",    held,          4'b0000);
        check("rst_async_press",   press,         4'b0000);
        check("rst_async_release", release_pulse, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        edges(5); check("rst_press_c5", press, 4'b0000);
        edges(1); check("rst_press_c6", press, 4'b1001);
                  check("rst_held_c6",  held,  4'b1001);
        edges(1); check("rst_press_c7", press, 4'b0000);
        drive(4'b1111);
        edges(12);

        // Long hold on key 0
        drive(4'b1110);
        for (int c = 1; c <= 60; c++) begin
            logic pulse_due;
            edges(1);
`ifdef KEY_REPEAT_EN
            pulse_due = (c == 6) || (c == 26) || (c == 34) || (c == 42) || (c == 50) || (c == 58);
`else
            pulse_due = (c == 6);
`endif
            check($sformatf("hold_press_c%0d", c), press, pulse_due ? 4'b0001 : 4'b0000);
        end
        drive(4'b1111);
        edges(12);
        check("final_held", held, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
